// File: rtl/pll_counter_checker_if.sv
// Bundle of the checker's control, counter-under-test and result signals.
// The master drives start/window/counter; the slave (checker) returns results.
interface pll_counter_checker_if #(
  parameter int WIDTH = 256,
  parameter int WIN_W = 32,
  parameter int ERR_W = 16
);
  logic             i_start;
  logic [WIN_W-1:0] i_window;
  logic [WIDTH-1:0] i_counter;
  logic             o_busy;
  logic             o_done;
  logic             o_pass;
  logic [ERR_W-1:0] o_err_count;
  logic [WIN_W-1:0] o_first_err_idx;
  logic [WIDTH-1:0] o_first_err_val;

  modport master (
    output i_start, i_window, i_counter,
    input  o_busy, o_done, o_pass, o_err_count, o_first_err_idx, o_first_err_val
  );

  modport slave (
    input  i_start, i_window, i_counter,
    output o_busy, o_done, o_pass, o_err_count, o_first_err_idx, o_first_err_val
  );
endinterface

// File: rtl/pll_counter_checker.sv
// Verifies a free-running counter advances by exactly one per clock over a
// programmable window; pass/fail, error count and first failure are registered.
module pll_counter_checker #(
  parameter int WIDTH = 256,
  parameter int WIN_W = 32,
  parameter int ERR_W = 16
) (
  input  logic                   clk,
  input  logic                   i_rst,
  pll_counter_checker_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIN_W-1:0] r_win,  w_win_nxt;
  logic [WIDTH-1:0] r_exp,  w_exp_nxt;
  logic [WIN_W-1:0] r_idx,  w_idx_nxt;
  logic [ERR_W-1:0] r_err,  w_err_nxt;
  logic [WIN_W-1:0] r_fidx, w_fidx_nxt;
  logic [WIDTH-1:0] r_fval, w_fval_nxt;
  logic             r_seen, w_seen_nxt;
  logic             r_pass, w_pass_nxt;
  logic             r_busy;
  logic             r_done;

  logic             w_mis;
  logic [ERR_W-1:0] w_err_inc;
  logic [WIN_W-1:0] w_last;

  // r_exp holds the already-incremented reference, so the compare is a plain equality
  assign w_mis     = (bus.i_counter != r_exp);
  assign w_err_inc = (r_err == {ERR_W{1'b1}}) ? r_err : (r_err + ERR_W'(1));
  assign w_last    = r_win - WIN_W'(1);

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    w_exp_nxt   = r_exp;
    w_idx_nxt   = r_idx;
    w_err_nxt   = r_err;
    w_fidx_nxt  = r_fidx;
    w_fval_nxt  = r_fval;
    w_seen_nxt  = r_seen;
    w_pass_nxt  = r_pass;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.i_start) begin
          w_state_nxt = S_PRIME;
          w_win_nxt   = bus.i_window;
          w_err_nxt   = '0;
          w_fidx_nxt  = '0;
          w_fval_nxt  = '0;
          w_seen_nxt  = 1'b0;
          w_pass_nxt  = 1'b0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_PRIME: begin
        w_exp_nxt = bus.i_counter + WIDTH'(1);
        w_idx_nxt = '0;
        if (r_win == '0) begin
          w_state_nxt = S_DONE;
          w_pass_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        // Resync on every cycle so a single skip costs exactly one error
        w_exp_nxt = bus.i_counter + WIDTH'(1);
        if (w_mis) begin
          w_err_nxt = w_err_inc;
          if (!r_seen) begin
            w_seen_nxt = 1'b1;
            w_fidx_nxt = r_idx;
            w_fval_nxt = bus.i_counter;
          end else begin
            w_seen_nxt = r_seen;
          end
        end else begin
          w_err_nxt = r_err;
        end
        if (r_idx == w_last) begin
          w_state_nxt = S_DONE;
          w_pass_nxt  = !w_mis && (r_err == '0);
        end else begin
          w_idx_nxt = r_idx + WIN_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_win   <= '0;
      r_exp   <= '0;
      r_idx   <= '0;
      r_err   <= '0;
      r_fidx  <= '0;
      r_fval  <= '0;
      r_seen  <= 1'b0;
      r_pass  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_win   <= w_win_nxt;
      r_exp   <= w_exp_nxt;
      r_idx   <= w_idx_nxt;
      r_err   <= w_err_nxt;
      r_fidx  <= w_fidx_nxt;
      r_fval  <= w_fval_nxt;
      r_seen  <= w_seen_nxt;
      r_pass  <= w_pass_nxt;
      r_busy  <= (w_state_nxt == S_PRIME) || (w_state_nxt == S_CHECK);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.o_busy          = r_busy;
  assign bus.o_done          = r_done;
  assign bus.o_pass          = r_pass;
  assign bus.o_err_count     = r_err;
  assign bus.o_first_err_idx = r_fidx;
  assign bus.o_first_err_val = r_fval;

endmodule

// File: tb/tb_pll_counter_checker.sv
// Directed self-checking bench for pll_counter_checker (ERR_W=4 so saturation
// is reachable), with hand-computed expectations per vector.
module tb_pll_counter_checker;

  localparam int WIDTH = 256;
  localparam int WIN_W = 32;
  localparam int ERR_W = 4;

  logic clk;
  logic i_rst;
  int   n_checks;
  int   n_fail;

  pll_counter_checker_if #(.WIDTH(WIDTH), .WIN_W(WIN_W), .ERR_W(ERR_W)) bus ();

  pll_counter_checker #(.WIDTH(WIDTH), .WIN_W(WIN_W), .ERR_W(ERR_W)) dut (
    .clk   (clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, WIDTH'(bus.o_busy), '0);
    check({tag, "_done"}, WIDTH'(bus.o_done), '0);
    check({tag, "_pass"}, WIDTH'(bus.o_pass), '0);
    check({tag, "_err"},  WIDTH'(bus.o_err_count), '0);
    check({tag, "_fidx"}, WIDTH'(bus.o_first_err_idx), '0);
    check({tag, "_fval"}, bus.o_first_err_val, '0);
  endtask

  // mode 0: clean increment, 1: extra +1 from comparison index s on, 2: stuck at c0
  task automatic run(input string tag, input logic [WIDTH-1:0] c0, input int win,
                     input int mode, input int s, input int abort_at, input bit poke,
                     input int exp_err, input bit exp_pass, input int exp_fidx,
                     input logic [WIDTH-1:0] exp_fval);
    int j;
    int nbusy;
    logic [WIDTH-1:0] v;
    bus.i_counter = c0;
    bus.i_window  = WIN_W'(win);
    bus.i_start   = 1'b1;
    step();
    bus.i_start = 1'b0;
    check({tag, "_busy_e0"}, WIDTH'(bus.o_busy), WIDTH'(1));
    check({tag, "_done_e0"}, WIDTH'(bus.o_done), '0);
    nbusy = 0;
    j = 1;
    while (bus.o_busy && (j < win + 20)) begin
      v = c0 + WIDTH'(j - 1);
      if (mode == 1 && (j - 2) >= s) v = v + WIDTH'(1);
      if (mode == 2) v = c0;
      bus.i_counter = v;
      if (poke) begin
        bus.i_start  = j[0];
        bus.i_window = '0;
      end
      step();
      nbusy++;
      if (abort_at >= 0 && j == abort_at + 2) return;
      j++;
    end
    bus.i_start = 1'b0;
    check({tag, "_busy_cycles"}, WIDTH'(nbusy), WIDTH'(win + 1));
    check({tag, "_done"}, WIDTH'(bus.o_done), WIDTH'(1));
    check({tag, "_pass"}, WIDTH'(bus.o_pass), WIDTH'(exp_pass));
    check({tag, "_err"},  WIDTH'(bus.o_err_count), WIDTH'(exp_err));
    check({tag, "_fidx"}, WIDTH'(bus.o_first_err_idx), WIDTH'(exp_fidx));
    check({tag, "_fval"}, bus.o_first_err_val, exp_fval);
    bus.i_counter = ~bus.i_counter;
    step();
    step();
    check({tag, "_done_held"}, WIDTH'(bus.o_done), WIDTH'(1));
    check({tag, "_err_held"},  WIDTH'(bus.o_err_count), WIDTH'(exp_err));
  endtask

  initial begin
    logic [WIDTH-1:0] wrap0;
    n_checks = 0;
    n_fail   = 0;
    i_rst         = 1'b1;
    bus.i_start   = 1'b0;
    bus.i_window  = '0;
    bus.i_counter = '0;
    repeat (2) step();
    check_all_zero("reset");
    #2 i_rst = 1'b0;
    step();

    run("clean", 256'h1000, 100, 0, 0, -1, 1'b0, 0, 1'b1, 0, '0);

    #2 i_rst = 1'b1;
    #1;
    check_all_zero("rst_idle");
    #1 i_rst = 1'b0;
    step();

    wrap0 = {WIDTH{1'b1}} - 256'd2;
    run("wrap", wrap0, 8, 0, 0, -1, 1'b0, 0, 1'b1, 0, '0);

    run("skip", 256'h5000, 50, 1, 10, -1, 1'b0, 1, 1'b0, 10, 256'h500C);

    run("stuck", 256'h77, 20, 2, 0, -1, 1'b0, 15, 1'b0, 0, 256'h77);

    run("zero", 256'h1, 0, 0, 0, -1, 1'b0, 0, 1'b1, 0, '0);

    run("abort", 256'h9000, 100, 1, 5, 30, 1'b0, 0, 1'b0, 0, '0);
    check("abort_busy_pre", WIDTH'(bus.o_busy), WIDTH'(1));
    check("abort_err_pre", WIDTH'(bus.o_err_count), WIDTH'(1));
    #2 i_rst = 1'b1;
    #1;
    check_all_zero("abort_rst");
    #1 i_rst = 1'b0;

    run("restart", 256'hABC, 5, 0, 0, -1, 1'b1, 0, 1'b1, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_counter_checker.md
# pll_counter_checker

Self-checking consumer of a PLL-branch free-running counter. Sits directly downstream of the per-branch test counter, in the same PLL output clock domain, and verifies that the counter advances by exactly one per clock over a programmable window. Results (pass/fail, error count, first-failure capture) are registered for readback over the debug VIO, replacing manual comparison of raw 256-bit snapshots.

## Interface

- `WIDTH`, 256, counter width under check
- `WIN_W`, 32, width of window length and index
- `ERR_W`, 16, width of saturating error counter

- `clk`  in  1  PLL branch clock, same clock as the counter being checked
- `i_rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `i_start`  in  1  single-cycle start request
- `i_window`  in  WIN_W  number of comparisons to perform; sampled on accepted start
- `i_counter`  in  WIDTH  counter value under check, synchronous to `clk`
- `o_busy`  out  1  high in PRIME and CHECK
- `o_done`  out  1  high in DONE; held until next accepted start
- `o_pass`  out  1  valid when `o_done`=1; 1 iff `o_err_count`=0
- `o_err_count`  out  ERR_W  mismatches seen this run; saturates at all-ones
- `o_first_err_idx`  out  WIN_W  comparison index of first mismatch
- `o_first_err_val`  out  WIDTH  `i_counter` value at first mismatch

## Operation

- States: IDLE, PRIME, CHECK, DONE. Reset → IDLE; all outputs and internal registers 0.
- IDLE or DONE, `i_start`=1: latch `i_window` into `r_win`; clear `o_err_count`, `o_first_err_idx`, `o_first_err_val`, `o_pass`; go PRIME.
- `i_start` in PRIME/CHECK: ignored, no effect on the run.
- PRIME (one cycle): `r_prev` ← `i_counter`, `r_idx` ← 0. If `r_win`=0: go DONE with `o_pass`=1. Else go CHECK.
- CHECK, every cycle:
  - expected = (`r_prev` + 1) mod 2^WIDTH; all-ones → 0 is a valid step.
  - mismatch if `i_counter` ≠ expected: `o_err_count` += 1 unless all-ones; if this is the first mismatch of the run, capture `r_idx` and `i_counter` into `o_first_err_idx`/`o_first_err_val`.
  - `r_prev` ← `i_counter` unconditionally (resync: a single skip or jump costs exactly one error).
  - if `r_idx` = `r_win`−1: go DONE, `o_pass` ← (final error count = 0, including this cycle's mismatch); else `r_idx` += 1.
- DONE: outputs frozen until next `i_start`.
- First-error capture uses a sticky internal flag, not `o_err_count`, so saturation cannot re-arm it.
- Counter reset by the debug VIO during CHECK appears as a jump to 0 → one mismatch, then clean.

## Timing

- `i_start` high at edge E0 → PRIME after E0; `o_busy`=1 from E0.
- Reference sampled at E1; comparisons at E2..E(`r_win`+1).
- `o_done`=1, `o_busy`=0, `o_pass` valid after E(`r_win`+1); busy time = `r_win`+1 cycles.
- `r_win`=0: DONE after E1.
- All outputs registered; no combinational path from inputs to outputs.
- `i_rst` asserted at any point: outputs 0 and state IDLE immediately (async); run aborted, no `o_done`. First start accepted on the first edge after release.
- Single comparator/adder on WIDTH bits per cycle; must close at PLL branch frequency (pipelining the `+1` into `r_prev` is permitted if externally visible timing is unchanged).

## Test plan

- Reset: assert `i_rst` mid-idle → all outputs 0, `o_busy`=0, `o_done`=0.
- Clean run: counter increments from 0x1000, `i_window`=100 → `o_busy` 101 cycles, `o_done`=1, `o_pass`=1, `o_err_count`=0.
- Wrap: counter starts at 2^256−3, `i_window`=8 → `o_pass`=1, no error at all-ones → 0.
- Single skip: counter jumps by 2 at comparison index 10, `i_window`=50 → `o_err_count`=1, `o_first_err_idx`=10, `o_first_err_val`=the skipped-to value, `o_pass`=0.
- Stuck counter, `ERR_W`=4, `i_window`=20 → `o_err_count`=15 (saturated), `o_first_err_idx`=0, `o_pass`=0; `i_window`=0 → `o_done` two cycles after start, `o_pass`=1.
- Reset mid-CHECK at index 30 of 100 → immediate IDLE, outputs 0; restart with `i_window`=5 → normal completion, `o_pass`=1; `i_start` pulses during CHECK have no effect.
